// File: rtl/jt10_adpcm_mix_pkg.sv
// Shared slot-decode constants and saturation helpers for the ADPCM mixer.
package jt10_adpcm_mix_pkg;

  localparam logic [5:0] FIRST_SLOT = 6'b000001;
  localparam logic [5:0] LAST_SLOT  = 6'b100000;

  // True when exactly one bit of a 6-bit slot vector is set.
  function automatic logic is_onehot6(input logic [5:0] v);
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

  // Clamp a wide signed sum into the 16-bit sample range.
  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return 16'sh7fff;
    end else if (v < -32'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

  // True when sat16 would alter the value.
  function automatic logic sat16_clips(input logic signed [31:0] v);
    return (v > 32'sd32767) || (v < -32'sd32768);
  endfunction

endpackage

// File: rtl/jt10_adpcm_mix_side.sv
// One stereo side of the mixer: accumulator, saturator and clip detect.
module jt10_adpcm_mix_side
  import jt10_adpcm_mix_pkg::*;
#(
  parameter int unsigned ACC_W = 19
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cen_i,
  input  logic                    slot_i,     // valid accumulate slot
  input  logic                    first_i,    // frame-start slot
  input  logic                    publish_i,  // frame-end slot with a frame seen
  input  logic signed [ACC_W-1:0] term_i,
  output logic signed [15:0]      pcm_o,
  output logic                    clip_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [31:0]      sum_ext;
  logic signed [15:0]      pcm_q;
  logic                    clip_q;

  // Running sum including the presented term; frame start discards history.
  always_comb begin
    acc_sum = acc_q + term_i;
    sum_ext = 32'(acc_sum);
    acc_d   = first_i ? term_i : acc_sum;
  end

  // Accumulator and published sample advance only on enabled slots.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      pcm_q  <= '0;
      clip_q <= 1'b0;
    end else if (cen_i) begin
      if (slot_i) begin
        acc_q <= acc_d;
      end
      if (publish_i) begin
        pcm_q  <= sat16(sum_ext);
        clip_q <= sat16_clips(sum_ext);
      end
    end
  end

  assign pcm_o  = pcm_q;
  assign clip_o = clip_q;

endmodule

// File: rtl/jt10_adpcm_mix.sv
// Six-channel ADPCM stereo mixer: one accumulate slot per channel per 36-cen frame.
module jt10_adpcm_mix
  import jt10_adpcm_mix_pkg::*;
#(
  parameter int unsigned ACC_W = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic [5:0]         cur_ch,
  input  logic [5:0]         en_ch,
  input  logic [1:0]         lr,
  input  logic [5:0]         ch_mute,
  input  logic signed [15:0] pcm_in,
  output logic signed [15:0] pcm_l,
  output logic signed [15:0] pcm_r,
  output logic               snd_sample,
  output logic               clipped
);

  logic                    slot_hit;
  logic                    first_slot;
  logic                    last_slot;
  logic                    publish;
  logic signed [ACC_W-1:0] ch_term;
  logic signed [ACC_W-1:0] term_l;
  logic signed [ACC_W-1:0] term_r;
  logic                    seen_q;
  logic                    snd_q;
  logic                    clip_l;
  logic                    clip_r;

  // Slot decode and per-side term selection.
  always_comb begin
    slot_hit   = is_onehot6(cur_ch) && is_onehot6(en_ch) && (cur_ch == en_ch);
    first_slot = slot_hit && (cur_ch == FIRST_SLOT);
    last_slot  = slot_hit && (cur_ch == LAST_SLOT);
    // Publishing needs a frame start since reset so a partial frame never escapes.
    publish    = last_slot && seen_q;
    ch_term    = ACC_W'(pcm_in);
    if ((cur_ch & ch_mute) != 6'd0) begin
      ch_term = '0;
    end
    term_l = lr[1] ? ch_term : '0;
    term_r = lr[0] ? ch_term : '0;
  end

  // Frame-seen flag and single-clk sample strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q <= 1'b0;
      snd_q  <= 1'b0;
    end else begin
      // Cleared every clk that does not publish, so wide cen cannot stretch it.
      snd_q <= cen && publish;
      if (cen && first_slot) begin
        seen_q <= 1'b1;
      end
    end
  end

  jt10_adpcm_mix_side #(
    .ACC_W(ACC_W)
  ) u_left (
    .clk_i    (clk),
    .rst_i    (rst),
    .cen_i    (cen),
    .slot_i   (slot_hit),
    .first_i  (first_slot),
    .publish_i(publish),
    .term_i   (term_l),
    .pcm_o    (pcm_l),
    .clip_o   (clip_l)
  );

  jt10_adpcm_mix_side #(
    .ACC_W(ACC_W)
  ) u_right (
    .clk_i    (clk),
    .rst_i    (rst),
    .cen_i    (cen),
    .slot_i   (slot_hit),
    .first_i  (first_slot),
    .publish_i(publish),
    .term_i   (term_r),
    .pcm_o    (pcm_r),
    .clip_o   (clip_r)
  );

  assign snd_sample = snd_q;
  assign clipped    = clip_l | clip_r;

endmodule

// File: tb/tb_jt10_adpcm_mix.sv
// Scoreboard bench for jt10_adpcm_mix: driver pushes per-frame expectations,
// a negedge monitor pops them on every snd_sample and checks hold behaviour.
module tb_jt10_adpcm_mix;

  logic               clk = 1'b0;
  logic               rst;
  logic               cen;
  logic [5:0]         cur_ch;
  logic [5:0]         en_ch;
  logic [1:0]         lr;
  logic [5:0]         ch_mute;
  logic signed [15:0] pcm_in;
  logic signed [15:0] pcm_l;
  logic signed [15:0] pcm_r;
  logic               snd_sample;
  logic               clipped;

  always #5 clk = ~clk;

  jt10_adpcm_mix #(
    .ACC_W(19)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .cur_ch    (cur_ch),
    .en_ch     (en_ch),
    .lr        (lr),
    .ch_mute   (ch_mute),
    .pcm_in    (pcm_in),
    .pcm_l     (pcm_l),
    .pcm_r     (pcm_r),
    .snd_sample(snd_sample),
    .clipped   (clipped)
  );

  typedef struct {
    int l;
    int r;
    int c;
  } exp_t;

  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         ch_pcm[6];
  logic [1:0] ch_lr[6];
  logic [5:0] mute_v;
  int         last_l = 0;
  int         last_r = 0;
  int         last_c = 0;
  int         prev_snd = 0;

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a frame's output is the clamped sum of unmuted channels routed to each side.
  task automatic push_expect();
    int   sl;
    int   sr;
    exp_t e;
    sl = 0;
    sr = 0;
    for (int ch = 0; ch < 6; ch++) begin
      if (!mute_v[ch]) begin
        if (ch_lr[ch][1]) sl += ch_pcm[ch];
        if (ch_lr[ch][0]) sr += ch_pcm[ch];
      end
    end
    e.l = clamp16(sl);
    e.r = clamp16(sr);
    e.c = ((sl != e.l) || (sr != e.r)) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // Monitor: pop on every strobe, otherwise outputs must hold the last published pair.
  always @(negedge clk) begin
    if (rst) begin
      last_l   = 0;
      last_r   = 0;
      last_c   = 0;
      prev_snd = 0;
    end else if (snd_sample) begin
      check("snd_width", prev_snd, 0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_snd: got strobe, expected none at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pcm_l", int'(pcm_l), e.l);
        check("pcm_r", int'(pcm_r), e.r);
        check("clipped", int'(clipped), e.c);
        last_l = e.l;
        last_r = e.r;
        last_c = e.c;
      end
      prev_snd = 1;
    end else begin
      check("hold_l", int'(pcm_l), last_l);
      check("hold_r", int'(pcm_r), last_r);
      check("hold_clip", int'(clipped), last_c);
      prev_snd = 0;
    end
  end

  // One cen slot followed by gap idle clks; gap 0 keeps cen high into the next slot.
  task automatic slot(input logic [5:0] c, input logic [5:0] e, input logic [1:0] l,
                      input logic [15:0] p, input int gap);
    cur_ch = c;
    en_ch  = e;
    lr     = l;
    pcm_in = p;
    cen    = 1'b1;
    @(posedge clk);
    #1;
    if (gap > 0) begin
      cen = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Drive slots [start, stop) of a frame; expectation pushed only for complete frames.
  task automatic run_frame(input int start, input int stop, input bit corrupt, input bit burst);
    int r;
    int p;
    int gap;
    if (start == 0 && stop == 36) push_expect();
    for (int s = start; s < stop; s++) begin
      r   = s / 6;
      p   = s % 6;
      gap = int'($urandom_range(0, 2));
      if (burst && s >= 34) gap = 0;
      ch_mute = mute_v;
      if (p == r) begin
        slot(6'(1 << p), 6'(1 << r), ch_lr[r], 16'(ch_pcm[r]), gap);
      end else if (corrupt) begin
        slot(6'b000011, 6'b000011, 2'b11, 16'h7fff, gap);
      end else begin
        slot(6'(1 << p), 6'(1 << r), 2'($urandom), 16'($urandom), gap);
      end
    end
  endtask

  task automatic set_all(input int v, input logic [1:0] l);
    for (int i = 0; i < 6; i++) begin
      ch_pcm[i] = v;
      ch_lr[i]  = l;
    end
  endtask

  initial begin
    rst     = 1'b1;
    cen     = 1'b0;
    cur_ch  = 6'd0;
    en_ch   = 6'd0;
    lr      = 2'b00;
    ch_mute = 6'd0;
    pcm_in  = 16'sd0;
    mute_v  = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pcm_l", int'(pcm_l), 0);
    check("rst_pcm_r", int'(pcm_r), 0);
    check("rst_clip", int'(clipped), 0);
    check("rst_snd", int'(snd_sample), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Ascending channel values on both sides: 2100.
    for (int i = 0; i < 6; i++) begin
      ch_pcm[i] = 100 * (i + 1);
      ch_lr[i]  = 2'b11;
    end
    run_frame(0, 36, 1'b0, 1'b0);
    run_frame(0, 36, 1'b0, 1'b0);

    // Positive saturation on left only.
    set_all(30000, 2'b10);
    run_frame(0, 36, 1'b0, 1'b0);

    // Negative saturation, then all but channel 0 muted.
    set_all(-30000, 2'b11);
    run_frame(0, 36, 1'b0, 1'b0);
    mute_v = 6'b111110;
    run_frame(0, 36, 1'b0, 1'b0);
    mute_v = 6'd0;

    // Non-one-hot slots carrying full-scale data must be ignored.
    for (int i = 0; i < 6; i++) begin
      ch_pcm[i] = int'($urandom_range(0, 4000)) - 2000;
      ch_lr[i]  = 2'($urandom);
    end
    run_frame(0, 36, 1'b1, 1'b0);

    // Reset in round 3: outputs clear at once, the partial remainder never publishes.
    run_frame(0, 18, 1'b0, 1'b0);
    cen = 1'b0;
    rst = 1'b1;
    #2;
    check("midrst_pcm_l", int'(pcm_l), 0);
    check("midrst_pcm_r", int'(pcm_r), 0);
    check("midrst_clip", int'(clipped), 0);
    check("midrst_snd", int'(snd_sample), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame(18, 36, 1'b0, 1'b0);
    run_frame(0, 36, 1'b0, 1'b0);

    // cen held high across frame end: strobe must stay one clk.
    set_all(1234, 2'b01);
    run_frame(0, 36, 1'b0, 1'b1);
    run_frame(0, 36, 1'b0, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < 6; i++) begin
        ch_pcm[i] = int'($urandom_range(0, 65535)) - 32768;
        ch_lr[i]  = 2'($urandom);
      end
      mute_v = 6'($urandom) & 6'($urandom);
      run_frame(0, 36, 1'b0, (f % 3) == 0);
    end

    cen = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jt10_adpcm_mix.md
JT10_ADPCM_MIX -- requirements
Module: jt10_adpcm_mix

Interface
REQ-001 SHALL have parameter ACC_W, default 19, the accumulator width in bits (16 data bits plus 3 headroom bits for six channels).
REQ-002 SHALL have port clk, input, 1 bit: the CPU clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port cen, input, 1 bit: 666 kHz clock enable; pipeline state advances only when it is high.
REQ-005 SHALL have port cur_ch, input, 6 bits: one-hot pipeline slot currently presented; rotates every cen.
REQ-006 SHALL have port en_ch, input, 6 bits: one-hot channel owning the current 6-cen round; rotates every round.
REQ-007 SHALL have port lr, input, 2 bits: routing for the presented slot; bit1 = left enable, bit0 = right enable.
REQ-008 SHALL have port ch_mute, input, 6 bits: per-channel mute, bit n mutes channel n.
REQ-009 SHALL have port pcm_in, input, signed 16 bits: attenuated sample for the presented slot.
REQ-010 SHALL have port pcm_l, output, signed 16 bits: mixed left sample.
REQ-011 SHALL have port pcm_r, output, signed 16 bits: mixed right sample.
REQ-012 SHALL have port snd_sample, output, 1 bit: one-clk pulse marking a new pcm_l/pcm_r pair.
REQ-013 SHALL have port clipped, output, 1 bit: high when the current published pair was saturated.

Function
REQ-014 A 36-cen frame SHALL consist of six rounds of six slots each.
REQ-015 An accumulate slot SHALL be any cen cycle with cur_ch == en_ch, both one-hot, giving exactly one slot per channel per frame.
REQ-016 A slot with non-one-hot cur_ch or en_ch SHALL be ignored.
REQ-017 Channel term SHALL be pcm_in sign-extended to ACC_W, forced to 0 when the channel's ch_mute bit is set.
REQ-018 The left term SHALL be the channel term when lr[1]=1 and 0 otherwise; the right term SHALL be the channel term when lr[0]=1 and 0 otherwise.
REQ-019 Frame-start slot (cur_ch[0]&en_ch[0]) SHALL load acc_l/acc_r with the terms, discarding the previous contents; other accumulate slots SHALL add the terms.
REQ-020 Frame-end slot (cur_ch[5]&en_ch[5]) SHALL, on the same cen edge, register pcm_l/pcm_r = sat16(acc + term), including channel 5's term.
REQ-021 sat16 SHALL clamp values >32767 to 32767 and values <-32768 to -32768.
REQ-022 clipped SHALL update together with pcm_l/pcm_r: 1 if either side saturated in that frame, else 0.
REQ-023 snd_sample SHALL go high on the clk edge that updates the outputs and SHALL last exactly one clk, independent of cen width.
REQ-024 Outputs SHALL hold their values between frame-end slots.
REQ-025 Publication SHALL be suppressed until a frame-start slot has been processed since reset; a partial first frame SHALL never publish.
REQ-026 Latency from the frame-end slot cen edge to the new outputs SHALL be 0 clk (registered on that edge).
REQ-027 When cen is low, no accumulator, output or flag state SHALL change, except that snd_sample SHALL fall.

Reset
REQ-028 While rst is high, acc_l, acc_r, pcm_l, pcm_r, clipped, snd_sample and the frame-seen flag SHALL be 0, applied asynchronously.
REQ-029 After a reset asserted mid-frame, the block SHALL resume per REQ-025.

Structure
REQ-030 A shared package SHALL hold the slot-decode constants FIRST_SLOT=6'b000001 and LAST_SLOT=6'b100000, plus the sat16 function.
REQ-031 One sub-module jt10_adpcm_mix_side SHALL be instantiated twice, once for left and once for right.
REQ-032 jt10_adpcm_mix_side SHALL contain the accumulator, the saturator and the clip detect.

Verification
REQ-033 Channels 0..5 at pcm 100,200,300,400,500,600 with lr=2'b11: pcm_l=pcm_r=2100, clipped=0, one snd_sample per 36 cen.
REQ-034 All channels at 30000 with lr=2'b10: pcm_l=32767, pcm_r=0, clipped=1.
REQ-035 All channels at -30000 with lr=2'b11, then ch_mute=6'b111110: first frame gives -32768 with clipped=1; the following frame gives -30000 with clipped=0.
REQ-036 Non-accumulate slots carrying pcm 7FFF and a corrupt en_ch=6'b000011: outputs unaffected by those slots.
REQ-037 rst pulsed at round 3: outputs 0 immediately, no snd_sample until a full frame completes after the next frame-start slot.
REQ-038 cen held high for 3 consecutive clk at frame end: snd_sample stays exactly 1 clk wide.
